// File: rtl/regfile_pkg.sv
// Shared constants and dump FSM state type for the 32x64 register file
// and its read-side consumers.
package regfile_pkg;

   localparam int NUM_REGS   = 32;
   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } dump_state_t;

endpackage

// File: rtl/regfile_dump_reader_out_stage.sv
// Valid/ready output register for the dump stream: holds one captured word
// until the consumer takes it.
module dump_out_stage
   import regfile_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [ADDR_WIDTH-1:0] index_i,
   input  logic                  out_ready_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [ADDR_WIDTH-1:0] out_index_o
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0] index_q, index_d;

   // A load always wins: the caller only loads when the slot is empty or
   // being emptied in the same cycle.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      index_d = index_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         index_d = index_i;
      end else if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         index_q <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         index_q <= index_d;
      end
   end

   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_index_o = index_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks every register-file address once per start and streams the values
// out over valid/ready, followed by a single-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; rd_addr parked at 0
// RUN   | presenting idx to the read port, loading words as the slot frees
// DRAIN | last word loaded, waiting for it to be accepted
// DONE  | one-cycle done pulse, start ignored
module regfile_dump_reader
   import regfile_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   input  logic [DATA_WIDTH-1:0] rd_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [ADDR_WIDTH-1:0] out_index_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   dump_state_t           state_q, state_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  load;
   logic                  out_valid;

   assign load = (state_q == RUN) && (!out_valid || out_ready_i);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // idx parks on the last address instead of wrapping
            if (load) begin
               if (idx_q == LAST_IDX) state_d = DRAIN;
               else                   idx_d   = idx_q + ADDR_WIDTH'(1);
            end
         end
         DRAIN: begin
            if (out_valid && out_ready_i) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   assign busy_o    = (state_q == RUN) || (state_q == DRAIN);
   assign done_o    = (state_q == DONE);
   assign rd_addr_o = busy_o ? idx_q : '0;

   dump_out_stage u_out_stage (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .load_i      (load),
      .data_i      (rd_data_i),
      .index_i     (idx_q),
      .out_ready_i (out_ready_i),
      .out_valid_o (out_valid),
      .out_data_o  (out_data_o),
      .out_index_o (out_index_o)
   );

   assign out_valid_o = out_valid;

endmodule
